// File: rtl/tdc_sample_averager.sv
// Burst averager for the TDC thermometer code.
// A start edge captures 2**LOG2_AVG samples. Each sample is popcount-encoded
// and accumulated. The block then reports mean, min and max through valid/ack.
module tdc_sample_averager #(
  parameter int N_DELAY  = 32,
  parameter int LOG2_AVG = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_DELAY-1:0]                 time_count,
  input  logic                               start_req,
  input  logic                               result_ack,
  output logic                               busy,
  output logic                               result_valid,
  output logic [$clog2(N_DELAY+1)-1:0]       result_avg,
  output logic [$clog2(N_DELAY+1)-1:0]       result_min,
  output logic [$clog2(N_DELAY+1)-1:0]       result_max
);
  localparam int CW = $clog2(N_DELAY+1);
  localparam int AW = CW + LOG2_AVG;
  localparam int NS = 1 << LOG2_AVG;
  localparam logic [LOG2_AVG-1:0] SLAST = LOG2_AVG'(NS - 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, DRAIN, DONE} state_t;

  state_t                state, state_nx;
  logic                  start_q, trigger;
  logic [N_DELAY-1:0]    in_q;
  logic [CW-1:0]         cnt_q;
  logic [1:0]            vld_pipe;   // [0]: in_q holds a burst sample, [1]: cnt_q does
  logic [LOG2_AVG-1:0]   scnt;
  logic                  dcnt;
  logic [AW-1:0]         sum_q, avg_full;
  logic [CW-1:0]         min_q, max_q;

  // Bubble-tolerant encoding: count of set taps, wherever they sit.
  function automatic logic [CW-1:0] popcount(input logic [N_DELAY-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_DELAY; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  assign trigger  = start_req & ~start_q;
  assign avg_full = sum_q >> LOG2_AVG;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; triggers are only seen in IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (trigger)                     state_nx = SAMPLE;
      SAMPLE: if (scnt == SLAST)               state_nx = DRAIN;
      DRAIN:  if (dcnt)                        state_nx = DONE;
      DONE:   if (result_valid && result_ack)  state_nx = IDLE;
      default:                                 state_nx = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state != IDLE);
  end

  // Input sync stage, encoder stage and sample-valid pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= 1'b0;
      in_q     <= '0;
      cnt_q    <= '0;
      vld_pipe <= '0;
    end else begin
      start_q  <= start_req;
      in_q     <= time_count;
      cnt_q    <= popcount(in_q);
      vld_pipe <= {vld_pipe[0], state == SAMPLE};
    end
  end

  // Sample counter and two-cycle drain counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt <= '0;
      dcnt <= 1'b0;
    end else begin
      if (state == IDLE && trigger) scnt <= '0;
      else if (state == SAMPLE)     scnt <= scnt + LOG2_AVG'(1);
      dcnt <= (state == DRAIN) ? ~dcnt : 1'b0;
    end
  end

  // Accumulate sum/min/max; cleared on an accepted trigger
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      min_q <= '0;
      max_q <= '0;
    end else if (state == IDLE && trigger) begin
      sum_q <= '0;
      min_q <= '1;
      max_q <= '0;
    end else if (vld_pipe[1]) begin
      sum_q <= sum_q + {{LOG2_AVG{1'b0}}, cnt_q};
      if (cnt_q < min_q) min_q <= cnt_q;
      if (cnt_q > max_q) max_q <= cnt_q;
    end
  end

  // Result registers: load once on entering DONE, drop valid on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      result_avg   <= '0;
      result_min   <= '0;
      result_max   <= '0;
    end else if (state == DONE && !result_valid) begin
      result_valid <= 1'b1;
      result_avg   <= avg_full[CW-1:0];
      result_min   <= min_q;
      result_max   <= max_q;
    end else if (result_valid && result_ack) begin
      result_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tdc_sample_averager.sv
// Directed + randomized bench for tdc_sample_averager with a burst-level model.
module tb_tdc_sample_averager;
  localparam int ND = 32;
  localparam int LA = 3;
  localparam int NS = 1 << LA;

  logic          clk = 0, rst_n = 0;
  logic [ND-1:0] time_count = '0;
  logic          start_req = 0, result_ack = 0;
  logic          busy, result_valid;
  logic [5:0]    result_avg, result_min, result_max;
  int            checks = 0, errors = 0;
  int            exp_avg, exp_min, exp_max;

  tdc_sample_averager #(.N_DELAY(ND), .LOG2_AVG(LA)) dut (
    .clk(clk), .rst_n(rst_n), .time_count(time_count), .start_req(start_req),
    .result_ack(result_ack), .busy(busy), .result_valid(result_valid),
    .result_avg(result_avg), .result_min(result_min), .result_max(result_max));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [ND-1:0] gen(input int mode, input int i);
    logic [ND-1:0] r;
    case (mode)
      0: r = 32'hFFFF_FFFF;
      1: r = (i % 2) ? 32'h0000_00FF : 32'h00FF_FFFF;
      2: r = 32'h0000_F0FF;
      3: r = '0;
      default: begin
        r = ND'($urandom);
        if ($urandom_range(0, 3) == 0) r = '0;
        if ($urandom_range(0, 3) == 0) r = '1;
      end
    endcase
    return r;
  endfunction

  // One full burst: trigger, N samples, exact latency check, handshake.
  // ack_dly: cycles to hold ack low after valid (-1 = ack held high throughout).
  task automatic burst(input string tag, input int mode, input int ack_dly,
                       input bit start_in_sample, input bit start_in_done);
    int sum, mn, mx, pc;
    sum = 0; mn = ND + 1; mx = -1;
    result_ack = (ack_dly < 0);
    start_req = 1;
    @(posedge clk);                      // E0
    @(negedge clk);
    start_req = 0;
    chk({tag, ":busy_e0"}, busy, 1);
    for (int i = 1; i <= NS; i++) begin
      time_count = gen(mode, i);
      pc = $countones(time_count);
      sum += pc;
      if (pc < mn) mn = pc;
      if (pc > mx) mx = pc;
      if (start_in_sample) start_req = (i == 4 || i == 5);
      @(posedge clk);                    // Ei captures this sample
      @(negedge clk);
      if (!busy) chk({tag, ":busy_sample"}, busy, 1);
    end
    start_req = 0;
    time_count = ND'($urandom);          // after the burst, must not matter
    exp_avg = sum / NS; exp_min = mn; exp_max = mx;
    @(posedge clk); @(negedge clk);      // EN+1
    chk({tag, ":valid_early1"}, result_valid, 0);
    @(posedge clk); @(negedge clk);      // EN+2
    chk({tag, ":valid_early2"}, result_valid, 0);
    @(posedge clk); @(negedge clk);      // EN+3 = E0+N+3
    chk({tag, ":valid_rise"}, result_valid, 1);
    chk({tag, ":avg"}, result_avg, exp_avg);
    chk({tag, ":min"}, result_min, exp_min);
    chk({tag, ":max"}, result_max, exp_max);
    if (ack_dly >= 0) begin
      for (int d = 0; d < ack_dly; d++) begin
        if (start_in_done) start_req = (d == 2);
        @(posedge clk); @(negedge clk);
        if (!(result_valid && busy && result_avg == 6'(exp_avg) &&
              result_min == 6'(exp_min) && result_max == 6'(exp_max)))
          chk({tag, ":hold_stable"}, {result_valid, busy, result_avg}, {1'b1, 1'b1, 6'(exp_avg)});
      end
      start_req = 0;
      result_ack = 1;
    end
    @(posedge clk); @(negedge clk);      // handshake edge
    result_ack = 0;
    chk({tag, ":valid_drop"}, result_valid, 0);
    chk({tag, ":busy_drop"}, busy, 0);
    if (start_in_sample || start_in_done) begin
      for (int d = 0; d < NS + 4; d++) begin
        @(posedge clk); @(negedge clk);
        if (busy || result_valid) chk({tag, ":no_queued"}, {busy, result_valid}, 0);
      end
      chk({tag, ":idle_after"}, {busy, result_valid}, 0);
    end
  endtask

  initial begin
    @(negedge clk);
    chk("reset:valid", result_valid, 0);
    chk("reset:busy", busy, 0);
    chk("reset:avg", result_avg, 0);
    chk("reset:minmax", {result_min, result_max}, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    burst("ones", 0, 0, 0, 0);
    burst("alt", 1, 1, 0, 0);
    chk("alt:avg16", exp_avg, 16);
    burst("bubble", 2, 0, 0, 0);
    burst("zero", 3, 0, 0, 0);
    burst("retrig", 4, 6, 1, 1);
    burst("hold20", 4, 20, 0, 0);
    burst("ackhi1", 4, -1, 0, 0);
    burst("ackhi2", 0, -1, 0, 0);

    // Abort mid-burst: reset asserted at sample 4 clears outputs immediately
    start_req = 1;
    @(posedge clk); @(negedge clk);
    start_req = 0;
    for (int i = 0; i < 4; i++) begin
      time_count = ND'($urandom);
      @(posedge clk); @(negedge clk);
    end
    #1 rst_n = 0;
    #1;
    chk("abort:busy", busy, 0);
    chk("abort:valid", result_valid, 0);
    chk("abort:avg", result_avg, 0);
    chk("abort:max", result_max, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (NS + 4) begin
      @(posedge clk); @(negedge clk);
      if (busy || result_valid) chk("abort:no_result", {busy, result_valid}, 0);
    end
    burst("post_abort", 1, 0, 0, 0);

    for (int r = 0; r < 6; r++) burst("rand", 4, int'($urandom_range(0, 3)), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
